lcm_controler_eg9013f_nz_axi_slave: RTL and testbench

//  AXI4-Lite slave front end of the EG9013F-NZ LCM IP. Terminates the S00_AXI bus and drives the

---
 rtl/lcm_controler_eg9013f_nz_axi_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_lcm_controler_eg9013f_nz_axi_slave.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_controler_eg9013f_nz_axi_slave.sv
// AXI4-Lite slave front end for the EG9013F-NZ LCM: converts S00_AXI traffic into
// single-cycle word-addressed write/read pulses on the RAM-stage port.
module lcm_controler_eg9013f_nz_axi_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned OPT_MEM_ADDR_BITS  = 10,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic                              ram_wen,
    output logic [OPT_MEM_ADDR_BITS-1:0]      ram_waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ram_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   ram_wstrb,
    output logic                              ram_ren,
    output logic [OPT_MEM_ADDR_BITS-1:0]      ram_raddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     ram_rdata
);

    localparam int unsigned ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OMB      = OPT_MEM_ADDR_BITS;
    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;

    typedef enum logic {
        WIdle,
        WResp
    } w_state_t;

    typedef enum logic [1:0] {
        RIdle,
        RIssue,
        RWait,
        RValid
    } r_state_t;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t            r_w_state;
    w_state_t            w_w_state_d;
    logic                r_aw_done;
    logic                w_aw_done_d;
    logic                r_w_done;
    logic                w_w_done_d;
    logic                r_awready;
    logic                w_awready_d;
    logic                r_wready;
    logic                w_wready_d;
    logic                r_bvalid;
    logic                w_bvalid_d;
    logic                r_wen;
    logic                w_wen_d;
    logic [OMB-1:0]      r_waddr;
    logic [OMB-1:0]      w_waddr_d;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       w_wdata_d;
    logic [STRB_W-1:0]   r_wstrb;
    logic [STRB_W-1:0]   w_wstrb_d;
    logic                w_aw_hs;
    logic                w_w_hs;

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi_wvalid && r_wready;

    always_comb begin
        w_w_state_d = r_w_state;
        w_aw_done_d = r_aw_done;
        w_w_done_d  = r_w_done;
        w_awready_d = 1'b0;
        w_wready_d  = 1'b0;
        w_bvalid_d  = r_bvalid;
        w_wen_d     = 1'b0;
        w_waddr_d   = r_waddr;
        w_wdata_d   = r_wdata;
        w_wstrb_d   = r_wstrb;
        case (r_w_state)
            WIdle: begin
                if (w_aw_hs) begin
                    w_aw_done_d = 1'b1;
                    // Upper byte-address bits are dropped, so the word address wraps.
                    w_waddr_d   = s_axi_awaddr[ADDR_LSB +: OMB];
                end
                if (w_w_hs) begin
                    w_w_done_d = 1'b1;
                    w_wdata_d  = s_axi_wdata;
                    w_wstrb_d  = s_axi_wstrb;
                end
                if (w_aw_done_d && w_w_done_d) begin
                    w_w_state_d = WResp;
                    w_wen_d     = 1'b1;
                    w_bvalid_d  = 1'b1;
                end else begin
                    w_awready_d = !w_aw_done_d;
                    w_wready_d  = !w_w_done_d;
                end
            end
            WResp: begin
                if (r_bvalid && s_axi_bready) begin
                    w_w_state_d = WIdle;
                    w_bvalid_d  = 1'b0;
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                    w_awready_d = 1'b1;
                    w_wready_d  = 1'b1;
                end
            end
            default: begin
                w_w_state_d = WIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_state <= WIdle;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_wen     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_w_state <= w_w_state_d;
            r_aw_done <= w_aw_done_d;
            r_w_done  <= w_w_done_d;
            r_awready <= w_awready_d;
            r_wready  <= w_wready_d;
            r_bvalid  <= w_bvalid_d;
            r_wen     <= w_wen_d;
            r_waddr   <= w_waddr_d;
            r_wdata   <= w_wdata_d;
            r_wstrb   <= w_wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t            r_r_state;
    r_state_t            w_r_state_d;
    logic                r_arready;
    logic                w_arready_d;
    logic                r_ren;
    logic                w_ren_d;
    logic                r_rvalid;
    logic                w_rvalid_d;
    logic [OMB-1:0]      r_raddr;
    logic [OMB-1:0]      w_raddr_d;
    logic [DW-1:0]       r_rdata;
    logic [DW-1:0]       w_rdata_d;

    always_comb begin
        w_r_state_d = r_r_state;
        w_arready_d = 1'b0;
        w_ren_d     = 1'b0;
        w_rvalid_d  = r_rvalid;
        w_raddr_d   = r_raddr;
        w_rdata_d   = r_rdata;
        case (r_r_state)
            RIdle: begin
                if (s_axi_arvalid && r_arready) begin
                    w_raddr_d   = s_axi_araddr[ADDR_LSB +: OMB];
                    w_ren_d     = 1'b1;
                    w_r_state_d = RIssue;
                end else begin
                    w_arready_d = 1'b1;
                end
            end
            RIssue: begin
                w_r_state_d = RWait;
            end
            RWait: begin
                // RAM stage returns data the cycle after the ren pulse.
                w_rdata_d   = ram_rdata;
                w_rvalid_d  = 1'b1;
                w_r_state_d = RValid;
            end
            RValid: begin
                if (s_axi_rready) begin
                    w_rvalid_d  = 1'b0;
                    w_arready_d = 1'b1;
                    w_r_state_d = RIdle;
                end
            end
            default: begin
                w_r_state_d = RIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r_state <= RIdle;
            r_arready <= 1'b0;
            r_ren     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_raddr   <= '0;
            r_rdata   <= '0;
        end else begin
            r_r_state <= w_r_state_d;
            r_arready <= w_arready_d;
            r_ren     <= w_ren_d;
            r_rvalid  <= w_rvalid_d;
            r_raddr   <= w_raddr_d;
            r_rdata   <= w_rdata_d;
        end
    end

    // Protection bits and the dropped address bits are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rvalid  = r_rvalid;
    assign ram_wen       = r_wen;
    assign ram_waddr     = r_waddr;
    assign ram_wdata     = r_wdata;
    assign ram_wstrb     = r_wstrb;
    assign ram_ren       = r_ren;
    assign ram_raddr     = r_raddr;

endmodule

// File: tb/tb_lcm_controler_eg9013f_nz_axi_slave.sv
// Bench for the LCM AXI4-Lite slave: directed table, hand-written corner sequences and
// random transactions checked against a word-memory reference model.
`timescale 1ns/1ps
module tb_lcm_controler_eg9013f_nz_axi_slave;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int OMB = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   s_axi_awaddr;
    logic [2:0]      s_axi_awprot;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic [2:0]      s_axi_arprot;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic            ram_wen;
    logic [OMB-1:0]  ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [3:0]      ram_wstrb;
    logic            ram_ren;
    logic [OMB-1:0]  ram_raddr;
    logic [DW-1:0]   ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcm_controler_eg9013f_nz_axi_slave #(
        .C_S_AXI_DATA_WIDTH (DW),
        .OPT_MEM_ADDR_BITS  (OMB),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ram_wen       (ram_wen),
        .ram_waddr     (ram_waddr),
        .ram_wdata     (ram_wdata),
        .ram_wstrb     (ram_wstrb),
        .ram_ren       (ram_ren),
        .ram_raddr     (ram_raddr),
        .ram_rdata     (ram_rdata)
    );

    // RAM stage: single-cycle read latency, read sees contents from before a same-cycle write.
    logic [DW-1:0] ram_mem [0:1023];
    logic          ram_clear;
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
            if (ram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) ram_mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: the memory map as seen through committed writes.
    logic [DW-1:0] ref_mem [0:1023];

    function automatic int word_of(input logic [AW-1:0] a);
        return (int'(a) / 4) % 1024;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s);
        int w;
        w = word_of(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, {23'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                              s_axi_rvalid, ram_wen, ram_ren, s_axi_bresp != 2'b00,
                              s_axi_rresp != 2'b00}, 32'd0);
        check({tag, " waddr"}, 32'(ram_waddr), 32'd0);
        check({tag, " raddr"}, 32'(ram_raddr), 32'd0);
        check({tag, " wdata"}, ram_wdata, 32'd0);
        check({tag, " wstrb"}, 32'(ram_wstrb), 32'd0);
        check({tag, " rdata"}, s_axi_rdata, 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input int exp_word);
        bit aw_ok;
        bit w_ok;
        int cyc;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        cyc   = 0;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            if (aw_ok) check("awready low after aw", 32'(s_axi_awready), 32'd0);
            if (w_ok)  check("wready low after w", 32'(s_axi_wready), 32'd0);
            check("no wen before both", 32'(ram_wen), 32'd0);
            s_axi_awvalid = !aw_ok && (cyc >= aw_dly);
            s_axi_wvalid  = !w_ok && (cyc >= w_dly);
            if (s_axi_awvalid && s_axi_awready) aw_ok = 1'b1;
            if (s_axi_wvalid && s_axi_wready) w_ok = 1'b1;
            step();
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) begin
            check("write handshake timeout", 32'd0, 32'd1);
            return;
        end
        check("wen pulse", 32'(ram_wen), 32'd1);
        check("waddr", 32'(ram_waddr), 32'(exp_word));
        check("wdata", ram_wdata, d);
        check("wstrb", 32'(ram_wstrb), 32'(s));
        check("bvalid with wen", 32'(s_axi_bvalid), 32'd1);
        check("bresp", 32'(s_axi_bresp), 32'd0);
        check("readies low in resp", 32'({s_axi_awready, s_axi_wready}), 32'd0);
        ref_write(a, d, s);
        for (int i = 0; i < b_dly; i++) begin
            s_axi_bready = 1'b0;
            step();
            check("wen single cycle", 32'(ram_wen), 32'd0);
            check("bvalid held", 32'(s_axi_bvalid), 32'd1);
        end
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check("bvalid cleared", 32'(s_axi_bvalid), 32'd0);
        check("write readies back", 32'({s_axi_awready, s_axi_wready}), 32'd3);
        check("no wen after resp", 32'(ram_wen), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                           input bit extra_ar, input int exp_word, input logic [DW-1:0] exp_d);
        bit ok;
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        s_axi_araddr = a;
        while (!ok && cyc < 40) begin
            check("no ren while idle", 32'(ram_ren), 32'd0);
            s_axi_arvalid = (cyc >= ar_dly);
            if (s_axi_arvalid && s_axi_arready) ok = 1'b1;
            step();
            cyc++;
        end
        s_axi_arvalid = extra_ar;
        s_axi_araddr  = a ^ AW'(12'h040);
        if (!ok) begin
            check("read handshake timeout", 32'd0, 32'd1);
            s_axi_arvalid = 1'b0;
            return;
        end
        check("ren at N+1", 32'(ram_ren), 32'd1);
        check("raddr", 32'(ram_raddr), 32'(exp_word));
        check("rvalid low N+1", 32'(s_axi_rvalid), 32'd0);
        check("arready low N+1", 32'(s_axi_arready), 32'd0);
        step();
        check("ren one cycle", 32'(ram_ren), 32'd0);
        check("rvalid low N+2", 32'(s_axi_rvalid), 32'd0);
        step();
        check("rvalid at N+3", 32'(s_axi_rvalid), 32'd1);
        check("rdata", s_axi_rdata, exp_d);
        check("rresp", 32'(s_axi_rresp), 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            s_axi_rready = 1'b0;
            step();
            check("rvalid held", 32'(s_axi_rvalid), 32'd1);
            check("rdata held", s_axi_rdata, exp_d);
            check("arready low while busy", 32'(s_axi_arready), 32'd0);
            check("no second ren", 32'(ram_ren), 32'd0);
        end
        s_axi_rready  = 1'b1;
        s_axi_arvalid = 1'b0;
        step();
        s_axi_rready = 1'b0;
        check("rvalid cleared", 32'(s_axi_rvalid), 32'd0);
        check("arready back", 32'(s_axi_arready), 32'd1);
    endtask

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        int            d1;
        int            d2;
        int            d3;
        bit            extra_ar;
        int            exp_word;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [3:0]    rs;

        vecs[0] = '{1'b1, 13'h0004, 32'h0000_0001, 4'hF, 0, 0, 0, 1'b0, 1, 32'h0};
        vecs[1] = '{1'b1, 13'h000C, 32'hDEAD_BEEF, 4'hF, 3, 0, 2, 1'b0, 3, 32'h0};
        vecs[2] = '{1'b1, 13'h0008, 32'hA5A5_0002, 4'hF, 0, 2, 0, 1'b0, 2, 32'h0};
        vecs[3] = '{1'b0, 13'h0008, 32'h0,         4'h0, 0, 0, 0, 1'b0, 2, 32'hA5A5_0002};
        vecs[4] = '{1'b1, 13'h1004, 32'h1122_3344, 4'h5, 1, 1, 1, 1'b0, 1, 32'h0};
        vecs[5] = '{1'b0, 13'h0004, 32'h0,         4'h0, 1, 5, 0, 1'b1, 1, 32'h0022_0044};
        vecs[6] = '{1'b0, 13'h0FFC, 32'h0,         4'h0, 0, 0, 0, 1'b0, 1023, 32'h0};
        vecs[7] = '{1'b0, 13'h100C, 32'h0,         4'h0, 2, 1, 0, 1'b0, 3, 32'hDEAD_BEEF};

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        ram_clear = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        step(); step(); step();
        ram_clear = 1'b0;
        check_all_zero("reset");
        rst_n = 1'b1;
        check("readies still low at release", 32'({s_axi_awready, s_axi_wready, s_axi_arready}),
              32'd0);
        step();
        check("readies after release", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2,
                         vecs[i].d3, vecs[i].exp_word);
            else
                do_read(vecs[i].addr, vecs[i].d1, vecs[i].d2, vecs[i].extra_ar,
                        vecs[i].exp_word, vecs[i].exp_rdata);
        end

        // Same-cycle write and read of word 0: read must return the old contents.
        s_axi_awaddr = '0; s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF;
        s_axi_araddr = '0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        check("all readies before collide", 32'({s_axi_awready, s_axi_wready, s_axi_arready}),
              32'd7);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("collide wen+ren", 32'({ram_wen, ram_ren}), 32'd3);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check("collide bvalid done", 32'(s_axi_bvalid), 32'd0);
        step();
        check("collide rvalid", 32'(s_axi_rvalid), 32'd1);
        check("collide rdata pre-write", s_axi_rdata, ref_mem[0]);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        ref_write('0, 32'h5555_AAAA, 4'hF);
        do_read('0, 0, 0, 1'b0, 0, 32'h5555_AAAA);

        // Reset while the read is in its wait cycle.
        s_axi_araddr = 13'h0008;
        s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        check("rst-read ren", 32'(ram_ren), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        check_all_zero("rst in r_wait");
        rst_n = 1'b1;
        step();
        check("readies after r rst", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        for (int i = 0; i < 4; i++) begin
            check("aborted read silent", 32'({s_axi_rvalid, ram_ren}), 32'd0);
            step();
        end

        // Reset while the write response is pending.
        s_axi_awaddr = 13'h0020; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rst-write wen+bvalid", 32'({ram_wen, s_axi_bvalid}), 32'd3);
        ref_write(13'h0020, 32'h0BAD_F00D, 4'hF);
        rst_n = 1'b0;
        step();
        check_all_zero("rst in w_resp");
        rst_n = 1'b1;
        step();
        check("readies after w rst", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        for (int i = 0; i < 4; i++) begin
            check("aborted write silent", 32'({s_axi_bvalid, ram_wen}), 32'd0);
            step();
        end
        do_read(13'h0020, 0, 0, 1'b0, 8, 32'h0BAD_F00D);

        // Random traffic against the reference memory.
        for (int n = 0; n < 60; n++) begin
            ra = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)
                     + $urandom_range(0, 1) * 4096);
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                do_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), word_of(ra));
            end else begin
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        word_of(ra), ref_mem[word_of(ra)]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
